framebuffer_arbiter: RTL and testbench
======================================

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter RD_MAX_WAIT, default 4: consecutive IDLE cycles a pending read may lose to writers before it gets absolute priority (1..15).
REQ-002 clk_main  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 wr0_req, wr1_req  in  1 each  write requests; the requester holds the request and its data until granted.
REQ-005 wr0_x, wr0_y, wr1_x, wr1_y  in  7 each  pixel write address.
REQ-006 wr0_data, wr1_data  in  16 each  RGB565 pixel write data.
REQ-007 wr0_gnt, wr1_gnt  out  1 each  combinational grant; a write transfers on the cycle where req and gnt are both 1.
REQ-008 rd_req  in  1; rd_x, rd_y  in  7 each  read request and address from the refresh path.
REQ-009 rd_gnt  out  1  combinational read grant; the read transfers on the cycle where rd_req and rd_gnt are both 1.
REQ-010 rd_data  out  16; rd_valid  out  1  read result, qualified by a 1-cycle rd_valid pulse.
REQ-011 mem_wr_en  out  1; mem_wr_addr_x, mem_wr_addr_y  out  7; mem_data_in  out  16  registered framebuffer write port.
REQ-012 mem_rd_en  out  1; mem_rd_addr_x, mem_rd_addr_y  out  7  registered framebuffer read port.
REQ-013 mem_data_out  in  16; mem_valid_out  in  1  read data from the framebuffer, valid when mem_valid_out=1.
REQ-014 busy  out  1  registered; 1 while state is READ_WAIT.

Function
REQ-015 The FSM has two states: IDLE and READ_WAIT; at most one framebuffer access is in flight, and reads and writes never overlap.
REQ-016 In READ_WAIT, all grants are 0.
REQ-017 In IDLE, at most one grant is 1 per cycle, and a grant is 1 only if the matching req is 1.
REQ-018 Writer choice is round-robin: a pointer names the preferred writer; after a wr0 grant wr1 is preferred, and after a wr1 grant wr0 is preferred. A lone requesting writer is always granted.
REQ-019 Reader vs writers: writers win unless the wait counter is >= RD_MAX_WAIT, in which case rd_gnt=1 and no writer is granted that cycle.
REQ-020 Wait counter: increments (saturating at 15) on each IDLE cycle with rd_req=1 and rd_gnt=0; it clears on rd_gnt or when rd_req=0.
REQ-021 Write accept at cycle N: at N+1, mem_wr_en=1 for exactly one cycle, with the granted address and data; the FSM stays in IDLE, so back-to-back writes run at 1 per cycle.
REQ-022 Read accept at cycle N: the address is latched and the FSM enters READ_WAIT; mem_rd_en=1 from N+1 and is held until mem_valid_out is sampled 1.
REQ-023 In READ_WAIT, mem_valid_out sampled 1 at cycle M causes, at M+1: rd_data=mem_data_out, rd_valid=1 for one cycle, mem_rd_en=0, state=IDLE.
REQ-024 A new grant is possible in the cycle rd_valid=1.
REQ-025 rd_req may drop during READ_WAIT; the read still completes and rd_valid still pulses.
REQ-026 mem_valid_out in IDLE is ignored.
REQ-027 No arithmetic on addresses: all 7-bit addresses pass through unmodified.
REQ-028 rd_data holds its last value between pulses.

Reset
REQ-029 rst=1 at an edge sets: state IDLE; mem_wr_en, mem_rd_en, rd_valid, busy = 0; rd_data, all mem addresses and mem_data_in = 0; wait counter 0; round-robin pointer = wr0.
REQ-030 Reset during READ_WAIT aborts the read: no rd_valid is produced, and a late mem_valid_out is ignored.
REQ-031 Grants are 0 while rst=1.

Verification
REQ-032 Both writers request continuously from reset (wr0 at (1,2) with 0xF800, wr1 at (3,4) with 0x07E0) -> grants alternate wr0, wr1, wr0..., and the mem_wr_en pulses carry the matching address and data one cycle after each grant.
REQ-033 Single read of (5,6) with mem_valid_out asserted 3 cycles after mem_rd_en rises and mem_data_out=0x1234 -> mem_rd_en high for exactly 3 cycles, then rd_valid one cycle with rd_data=0x1234, busy low on that cycle.
REQ-034 With RD_MAX_WAIT=4, rd_req held while wr0 requests continuously -> rd_gnt on the 5th cycle of rd_req, with wr0_gnt=0 that cycle; wr0 resumes after rd_valid.
REQ-035 rst pulsed 1 cycle after a read accept, then mem_valid_out asserted -> no rd_valid, mem_rd_en=0, and state is IDLE after reset.
REQ-036 rd_req dropped the cycle after rd_gnt -> the read completes and rd_valid pulses once.
REQ-037 wr0_req and rd_req together from reset with wait counter 0 -> wr0_gnt=1 and rd_gnt=0 on the first cycle.

Source files
------------

// File: rtl/framebuffer_arbiter_if.sv
// Request/grant and framebuffer port bundle for the framebuffer arbiter.
// slave = arbiter side, master = requesters plus framebuffer side.
interface framebuffer_arbiter_if;
    logic        wr0_req;
    logic [6:0]  wr0_x;
    logic [6:0]  wr0_y;
    logic [15:0] wr0_data;
    logic        wr0_gnt;
    logic        wr1_req;
    logic [6:0]  wr1_x;
    logic [6:0]  wr1_y;
    logic [15:0] wr1_data;
    logic        wr1_gnt;
    logic        rd_req;
    logic [6:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_gnt;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        mem_wr_en;
    logic [6:0]  mem_wr_addr_x;
    logic [6:0]  mem_wr_addr_y;
    logic [15:0] mem_data_in;
    logic        mem_rd_en;
    logic [6:0]  mem_rd_addr_x;
    logic [6:0]  mem_rd_addr_y;
    logic [15:0] mem_data_out;
    logic        mem_valid_out;
    logic        busy;

    modport slave (
        input  wr0_req, wr0_x, wr0_y, wr0_data,
        input  wr1_req, wr1_x, wr1_y, wr1_data,
        input  rd_req, rd_x, rd_y,
        input  mem_data_out, mem_valid_out,
        output wr0_gnt, wr1_gnt, rd_gnt, rd_data, rd_valid,
        output mem_wr_en, mem_wr_addr_x, mem_wr_addr_y, mem_data_in,
        output mem_rd_en, mem_rd_addr_x, mem_rd_addr_y, busy
    );

    modport master (
        output wr0_req, wr0_x, wr0_y, wr0_data,
        output wr1_req, wr1_x, wr1_y, wr1_data,
        output rd_req, rd_x, rd_y,
        output mem_data_out, mem_valid_out,
        input  wr0_gnt, wr1_gnt, rd_gnt, rd_data, rd_valid,
        input  mem_wr_en, mem_wr_addr_x, mem_wr_addr_y, mem_data_in,
        input  mem_rd_en, mem_rd_addr_x, mem_rd_addr_y, busy
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Arbitrates two pixel writers and one refresh reader onto a single framebuffer
// port: round-robin between writers, reader gets priority after waiting too long.
module framebuffer_arbiter #(
    parameter int RD_MAX_WAIT = 4
) (
    input  logic                  clk_main,
    input  logic                  rst,
    framebuffer_arbiter_if.slave  bus
);
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] READ_WAIT = 1'b1;

    logic [0:0]  state_reg;
    logic        ptr_reg;
    logic [3:0]  wait_cnt_reg;
    logic        mem_wr_en_reg;
    logic [6:0]  mem_wr_addr_x_reg;
    logic [6:0]  mem_wr_addr_y_reg;
    logic [15:0] mem_data_in_reg;
    logic        mem_rd_en_reg;
    logic [6:0]  mem_rd_addr_x_reg;
    logic [6:0]  mem_rd_addr_y_reg;
    logic [15:0] rd_data_reg;
    logic        rd_valid_reg;

    logic in_idle;
    logic rd_prio;
    logic wr_allowed;
    logic wr0_gnt;
    logic wr1_gnt;
    logic rd_gnt;

    // Grants only exist in IDLE and never while reset is asserted.
    assign in_idle    = (state_reg == IDLE) && !rst;
    assign rd_prio    = (wait_cnt_reg >= 4'(RD_MAX_WAIT));
    assign wr_allowed = in_idle && !(bus.rd_req && rd_prio);
    assign wr0_gnt    = wr_allowed && bus.wr0_req && (!bus.wr1_req || !ptr_reg);
    assign wr1_gnt    = wr_allowed && bus.wr1_req && (!bus.wr0_req ||  ptr_reg);
    assign rd_gnt     = in_idle && bus.rd_req && (rd_prio || !(bus.wr0_req || bus.wr1_req));

    assign bus.wr0_gnt       = wr0_gnt;
    assign bus.wr1_gnt       = wr1_gnt;
    assign bus.rd_gnt        = rd_gnt;
    assign bus.rd_data       = rd_data_reg;
    assign bus.rd_valid      = rd_valid_reg;
    assign bus.mem_wr_en     = mem_wr_en_reg;
    assign bus.mem_wr_addr_x = mem_wr_addr_x_reg;
    assign bus.mem_wr_addr_y = mem_wr_addr_y_reg;
    assign bus.mem_data_in   = mem_data_in_reg;
    assign bus.mem_rd_en     = mem_rd_en_reg;
    assign bus.mem_rd_addr_x = mem_rd_addr_x_reg;
    assign bus.mem_rd_addr_y = mem_rd_addr_y_reg;
    assign bus.busy          = (state_reg == READ_WAIT);

    always_ff @(posedge clk_main) begin
        if (rst) begin
            state_reg         <= IDLE;
            ptr_reg           <= 1'b0;
            wait_cnt_reg      <= 4'd0;
            mem_wr_en_reg     <= 1'b0;
            mem_wr_addr_x_reg <= 7'd0;
            mem_wr_addr_y_reg <= 7'd0;
            mem_data_in_reg   <= 16'd0;
            mem_rd_en_reg     <= 1'b0;
            mem_rd_addr_x_reg <= 7'd0;
            mem_rd_addr_y_reg <= 7'd0;
            rd_data_reg       <= 16'd0;
            rd_valid_reg      <= 1'b0;
        end else begin
            mem_wr_en_reg <= wr0_gnt || wr1_gnt;
            rd_valid_reg  <= 1'b0;

            if (wr0_gnt) begin
                mem_wr_addr_x_reg <= bus.wr0_x;
                mem_wr_addr_y_reg <= bus.wr0_y;
                mem_data_in_reg   <= bus.wr0_data;
                ptr_reg           <= 1'b1;
            end else if (wr1_gnt) begin
                mem_wr_addr_x_reg <= bus.wr1_x;
                mem_wr_addr_y_reg <= bus.wr1_y;
                mem_data_in_reg   <= bus.wr1_data;
                ptr_reg           <= 1'b0;
            end

            // Starvation counter: only losing IDLE cycles count up.
            if (!bus.rd_req || rd_gnt) begin
                wait_cnt_reg <= 4'd0;
            end else if (state_reg == IDLE && wait_cnt_reg != 4'd15) begin
                wait_cnt_reg <= wait_cnt_reg + 4'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (rd_gnt) begin
                        state_reg         <= READ_WAIT;
                        mem_rd_en_reg     <= 1'b1;
                        mem_rd_addr_x_reg <= bus.rd_x;
                        mem_rd_addr_y_reg <= bus.rd_y;
                    end
                end
                READ_WAIT: begin
                    if (bus.mem_valid_out) begin
                        state_reg     <= IDLE;
                        mem_rd_en_reg <= 1'b0;
                        rd_data_reg   <= bus.mem_data_out;
                        rd_valid_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter: writer round-robin, read latency,
// reader starvation priority, and reset abort of an in-flight read.
module tb_framebuffer_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic prev0;

    framebuffer_arbiter_if bus ();

    framebuffer_arbiter #(.RD_MAX_WAIT(4)) dut (
        .clk_main (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.wr0_req       = 1'b1;
        bus.wr0_x         = 7'd1;
        bus.wr0_y         = 7'd2;
        bus.wr0_data      = 16'hF800;
        bus.wr1_req       = 1'b1;
        bus.wr1_x         = 7'd3;
        bus.wr1_y         = 7'd4;
        bus.wr1_data      = 16'h07E0;
        bus.rd_req        = 1'b0;
        bus.rd_x          = 7'd0;
        bus.rd_y          = 7'd0;
        bus.mem_data_out  = 16'd0;
        bus.mem_valid_out = 1'b0;

        // Reset state, grants suppressed while rst is high.
        next(); next(); #1;
        chk("rst_wr0_gnt",   32'(bus.wr0_gnt), 0);
        chk("rst_wr1_gnt",   32'(bus.wr1_gnt), 0);
        chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rst_mem_rd_en", 32'(bus.mem_rd_en), 0);
        chk("rst_rd_valid",  32'(bus.rd_valid), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_rd_data",   32'(bus.rd_data), 0);
        chk("rst_wr_addr_x", 32'(bus.mem_wr_addr_x), 0);
        chk("rst_data_in",   32'(bus.mem_data_in), 0);

        // Both writers continuously: wr0, wr1, wr0 ... and write pulses lag by 1.
        next();
        rst   = 1'b0;
        prev0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_wr0_gnt", 32'(bus.wr0_gnt), (i % 2 == 0) ? 1 : 0);
            chk("rr_wr1_gnt", 32'(bus.wr1_gnt), (i % 2 == 0) ? 0 : 1);
            if (i > 0) begin
                chk("rr_mem_wr_en", 32'(bus.mem_wr_en), 1);
                chk("rr_addr_x", 32'(bus.mem_wr_addr_x), prev0 ? 1 : 3);
                chk("rr_addr_y", 32'(bus.mem_wr_addr_y), prev0 ? 2 : 4);
                chk("rr_data",   32'(bus.mem_data_in), prev0 ? 'hF800 : 'h07E0);
            end
            prev0 = (i % 2 == 0);
            next();
        end
        bus.wr0_req = 1'b0;
        bus.wr1_req = 1'b0;
        #1;
        chk("rr_last_wr_en", 32'(bus.mem_wr_en), 1);
        chk("rr_last_addr",  32'(bus.mem_wr_addr_x), 3);
        chk("rr_last_data",  32'(bus.mem_data_in), 'h07E0);
        chk("rr_idle_gnt",   32'(bus.wr0_gnt | bus.wr1_gnt), 0);
        next(); #1;
        chk("rr_wr_en_off",  32'(bus.mem_wr_en), 0);

        // Reader vs continuous wr0: writers win 4 cycles, reader wins the 5th.
        bus.wr0_req = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_x    = 7'd9;
        bus.rd_y    = 7'd10;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("starve_wr0_gnt", 32'(bus.wr0_gnt), (k < 5) ? 1 : 0);
            chk("starve_rd_gnt",  32'(bus.rd_gnt),  (k == 5) ? 1 : 0);
            if (k < 5) next();
        end
        next();
        bus.rd_req        = 1'b0;
        bus.mem_valid_out = 1'b1;
        bus.mem_data_out  = 16'hABCD;
        #1;
        chk("rw_busy",      32'(bus.busy), 1);
        chk("rw_mem_rd_en", 32'(bus.mem_rd_en), 1);
        chk("rw_rd_addr_x", 32'(bus.mem_rd_addr_x), 9);
        chk("rw_rd_addr_y", 32'(bus.mem_rd_addr_y), 10);
        chk("rw_wr0_gnt",   32'(bus.wr0_gnt), 0);
        chk("rw_mem_wr_en", 32'(bus.mem_wr_en), 0);
        next();
        bus.mem_valid_out = 1'b0;
        #1;
        chk("drop_rd_valid", 32'(bus.rd_valid), 1);
        chk("drop_rd_data",  32'(bus.rd_data), 'hABCD);
        chk("drop_busy",     32'(bus.busy), 0);
        chk("drop_rd_en",    32'(bus.mem_rd_en), 0);
        chk("resume_wr0",    32'(bus.wr0_gnt), 1);
        next();
        bus.wr0_req = 1'b0;
        #1;
        chk("pulse_once",    32'(bus.rd_valid), 0);
        chk("hold_rd_data",  32'(bus.rd_data), 'hABCD);
        chk("resume_wr_en",  32'(bus.mem_wr_en), 1);
        chk("resume_data",   32'(bus.mem_data_in), 'hF800);

        // Single read (5,6): valid in the 3rd cycle of mem_rd_en.
        next();
        bus.rd_req = 1'b1;
        bus.rd_x   = 7'd5;
        bus.rd_y   = 7'd6;
        #1;
        chk("rd_gnt_alone", 32'(bus.rd_gnt), 1);
        next();
        bus.rd_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("rd_en_held", 32'(bus.mem_rd_en), 1);
            chk("rd_busy",    32'(bus.busy), 1);
            if (c == 1) begin
                chk("rd_addr_x", 32'(bus.mem_rd_addr_x), 5);
                chk("rd_addr_y", 32'(bus.mem_rd_addr_y), 6);
            end
            if (c == 3) begin
                bus.mem_valid_out = 1'b1;
                bus.mem_data_out  = 16'h1234;
            end
            next();
        end
        bus.mem_valid_out = 1'b0;
        #1;
        chk("rd_en_off",   32'(bus.mem_rd_en), 0);
        chk("rd_valid",    32'(bus.rd_valid), 1);
        chk("rd_data",     32'(bus.rd_data), 'h1234);
        chk("rd_busy_low", 32'(bus.busy), 0);
        bus.mem_valid_out = 1'b1;
        bus.mem_data_out  = 16'h5555;
        next();
        bus.mem_valid_out = 1'b0;
        #1;
        chk("idle_valid_ignored", 32'(bus.rd_valid), 0);
        chk("idle_data_kept",     32'(bus.rd_data), 'h1234);

        // Reset one cycle after a read accept aborts the read.
        bus.rd_req = 1'b1;
        bus.rd_x   = 7'd7;
        bus.rd_y   = 7'd8;
        #1;
        chk("abort_rd_gnt", 32'(bus.rd_gnt), 1);
        next();
        bus.rd_req = 1'b0;
        rst        = 1'b1;
        #1;
        chk("abort_rd_en_pre", 32'(bus.mem_rd_en), 1);
        chk("abort_addr_pre",  32'(bus.mem_rd_addr_x), 7);
        next();
        rst               = 1'b0;
        bus.mem_valid_out = 1'b1;
        bus.mem_data_out  = 16'h9999;
        #1;
        chk("abort_rd_en",   32'(bus.mem_rd_en), 0);
        chk("abort_busy",    32'(bus.busy), 0);
        chk("abort_valid",   32'(bus.rd_valid), 0);
        chk("abort_rd_data", 32'(bus.rd_data), 0);
        chk("abort_addr",    32'(bus.mem_rd_addr_x), 0);
        bus.wr0_req = 1'b1;
        bus.wr1_req = 1'b1;
        #1;
        chk("abort_idle_wr0", 32'(bus.wr0_gnt), 1);
        chk("abort_idle_wr1", 32'(bus.wr1_gnt), 0);
        next();
        bus.mem_valid_out = 1'b0;
        bus.wr0_req       = 1'b0;
        bus.wr1_req       = 1'b0;
        #1;
        chk("abort_late_valid", 32'(bus.rd_valid), 0);
        chk("abort_wr_en",      32'(bus.mem_wr_en), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
